encoder_8x3_seq: RTL and testbench
==================================

ENCODER_8X3_SEQ -- requirements
Module: encoder_8x3_seq

Interface
REQ-001 The block SHALL have these ports, in this order:
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 load  input  1  request to capture D; honoured only in IDLE.
REQ-005 D  input  8  line vector; bit i set = line i active; bit 7 highest priority.
REQ-006 ready  input  1  consumer accepts the current code this cycle.
REQ-007 code  output  3  index of the highest set pending line, {x,y,z}, x = MSB.
REQ-008 valid  output  1  code is meaningful.
REQ-009 busy  output  1  high in EMIT state.
REQ-010 count  output  4  number of pending lines, 0..8.
REQ-011 none  output  1  one-cycle pulse after a load of D = 0.

Function
REQ-012 State SHALL be a two-state FSM (IDLE, EMIT), plus an 8-bit pending register and a 1-bit none register.
REQ-013 IDLE, load=1, D!=0: pending <= D; go to EMIT; valid=1 from the next cycle (latency 1).
REQ-014 IDLE, load=1, D=0: stay IDLE; none=1 for exactly the next cycle; valid stays 0.
REQ-015 In IDLE, none SHALL be 0 in every cycle that does not follow a load of D=0.
REQ-016 In EMIT: valid=1; busy=1; code = index of the highest set bit of pending.
REQ-017 EMIT with ready=1 is a transfer; that cycle's code bit SHALL be cleared from pending.
REQ-018 If pending is zero after the clear: go to IDLE; valid=0 and busy=0 from the next cycle.
REQ-019 If pending is nonzero after the clear: stay EMIT; next code from the next cycle.
REQ-020 Throughput: with ready held high, one code per cycle; k set bits take exactly k cycles.
REQ-021 EMIT with ready=0: code, valid, count and pending SHALL hold unchanged.
REQ-022 load in EMIT SHALL be ignored, including on the final transfer cycle; D is not sampled.
REQ-023 count SHALL equal the popcount of pending, using 4-bit unsigned width so 8 is representable.
REQ-024 code, valid, busy, count and none SHALL depend only on registered state, with no combinational path from any input.
REQ-025 In IDLE, code SHALL be 3'b000 and count SHALL be 0.

Reset
REQ-026 rst_n=0 sampled at a clk edge SHALL force IDLE, pending=0, none=0.
REQ-027 After that edge: valid=0, busy=0, code=0, count=0, none=0.
REQ-028 Reset SHALL take priority over load and ready in the same cycle.
REQ-029 Reset mid-EMIT SHALL discard the remaining codes; no code SHALL be emitted after it.
REQ-030 Outputs are undefined before the first clk edge with rst_n=0; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-031 Load D=8'hAA, ready=1 -> code 7,5,3,1 on four consecutive cycles; count 4,3,2,1; then valid=0, busy=0.
REQ-032 Load D=8'h81, ready=0 for 3 cycles -> code=7, valid=1, count=2 held; then ready=1 -> codes 7, 0; then IDLE.
REQ-033 Load D=8'h00 -> none=1 for one cycle; valid=0, busy=0 throughout.
REQ-034 Load D=8'h0F, then load D=8'hF0 during EMIT -> only codes 3,2,1,0 are emitted; 8'hF0 is never captured.
REQ-035 Load D=8'hFF, ready=1 -> codes 7..0 over 8 cycles; count starts at 8.
REQ-036 Load D=8'hFF, rst_n=0 after 2 transfers -> next cycle valid=0, count=0, busy=0; no further codes.

Source files
------------

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 priority encoder: captures a line vector, then emits the
// index of each set line, highest first, one per accepted handshake.
module encoder_8x3_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] D,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic       busy,
    output logic [3:0] count,
    output logic       none
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EMIT = 1'b1;

    logic       state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       none_q, none_d;

    logic [2:0] highIdx;
    logic [3:0] popCount;

    // Ascending scan so the last hit is the highest set line.
    always_comb begin
        highIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                highIdx = 3'(i);
            end
        end
    end

    always_comb begin
        popCount = 4'd0;
        for (int i = 0; i < 8; i++) begin
            popCount = popCount + {3'd0, pending_q[i]};
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        none_d    = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (load) begin
                    if (D != 8'd0) begin
                        pending_d = D;
                        state_d   = STATE_EMIT;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            STATE_EMIT: begin
                // load is deliberately ignored here, even on the last transfer.
                if (ready) begin
                    pending_d = pending_q & ~(8'b0000_0001 << highIdx);
                    if (pending_d == 8'd0) begin
                        state_d = STATE_IDLE;
                    end
                end
            end
            default: begin
                state_d   = STATE_IDLE;
                pending_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            pending_q <= 8'd0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            none_q    <= none_d;
        end
    end

    // All outputs derive from registered state only.
    assign valid = (state_q == STATE_EMIT);
    assign busy  = (state_q == STATE_EMIT);
    assign code  = (state_q == STATE_EMIT) ? highIdx : 3'd0;
    assign count = popCount;
    assign none  = none_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Directed self-checking bench for encoder_8x3_seq; compares the packed
// output vector {valid,busy,code,count,none} against hand-computed values.
module tb_encoder_8x3_seq;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] D;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic       busy;
    logic [3:0] count;
    logic       none;

    int checks = 0;
    int errors = 0;

    encoder_8x3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .D     (D),
        .ready (ready),
        .code  (code),
        .valid (valid),
        .busy  (busy),
        .count (count),
        .none  (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1ns after the edge before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst_n = 1'b0;
        load  = 1'b1;
        D     = 8'hFF;
        ready = 1'b1;
        tick();
        tick();
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        load  = 1'b0;
        D     = 8'h00;
        ready = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
    endtask

    task automatic test_aa_stream();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'hAA;
        ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 1'b1, 3'(7 - 2 * i), 4'(4 - i), 1'b0};
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL aa_emit[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL aa_done_idle: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'h81;
        ready = 1'b0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = {1'b1, 1'b1, 3'd7, 4'd2, 1'b0};
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL hold_81[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        ready = 1'b1;
        exp = {1'b1, 1'b1, 3'd7, 4'd2, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL release_81_first: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 3'd0, 4'd1, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL release_81_second: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        tick();
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL release_81_idle: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        ready = 1'b0;
    endtask

    task automatic test_none_pulse();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'h00;
        ready = 1'b0;
        tick();
        load = 1'b0;
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b1};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL none_pulse: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        tick();
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL none_cleared: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
    endtask

    task automatic test_load_ignored_in_emit();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'h0F;
        ready = 1'b1;
        tick();
        D = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 1'b1, 3'(3 - i), 4'(4 - i), 1'b0};
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL ignore_load_emit[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL ignore_load_final: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        load = 1'b0;
        tick();
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL ignore_load_stays_idle: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'hFF;
        ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 3'(7 - i), 4'(8 - i), 1'b0};
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL ff_emit[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        checks++;
        if ({valid, busy, code, count, none} !== exp) begin
            errors++;
            $display("[TB] FAIL ff_done_idle: {valid,busy,code,count,none} actual=%b expected=%b",
                     {valid, busy, code, count, none}, exp);
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        logic [9:0] exp;
        load  = 1'b1;
        D     = 8'hFF;
        ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp = {1'b1, 1'b1, 3'(7 - i), 4'(8 - i), 1'b0};
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_pre[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp = {1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid, busy, code, count, none} !== exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_post[%0d]: {valid,busy,code,count,none} actual=%b expected=%b",
                         i, {valid, busy, code, count, none}, exp);
            end
            tick();
        end
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        D     = 8'h00;
        ready = 1'b0;
        test_reset();
        test_aa_stream();
        test_backpressure();
        test_none_pulse();
        test_load_ignored_in_emit();
        test_back_to_back();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
